// File: rtl/mux3_rr_arbiter_if.sv
// mux3_rr_arbiter_if: request/grant/select bundle between requesters and the arbiter
interface mux3_rr_arbiter_if;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  modport master(output req, input gnt, sel, busy);
  modport slave(input req, output gnt, sel, busy);
endinterface

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin arbiter with capped grant length driving a shared mux3 select
module mux3_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic              clk,
  input logic              reset_n,
  mux3_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] HM = 8'(HOLD_MAX);
  state_t     state, state_n;
  logic [1:0] last, last_n, sel_n, base, c1, c2, win;
  logic [7:0] cnt, cnt_n;
  logic [2:0] gnt_n;
  logic       keep, any;
  always_comb begin
    any     = |bus.req;
    base    = state == GRANT ? bus.sel : last;
    c1      = base == 2'd2 ? 2'd0 : base + 2'd1;
    c2      = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
    win     = bus.req[c1] ? c1 : bus.req[c2] ? c2 : base;
    keep    = state == GRANT && bus.req[bus.sel] && cnt < HM;
    state_n = any ? GRANT : IDLE;
    cnt_n   = keep ? cnt + 8'd1 : any ? 8'd1 : 8'd0;
    sel_n   = keep || !any ? bus.sel : win;
    gnt_n   = !any ? 3'b000 : keep ? bus.gnt : 3'b001 << win;
    last_n  = state == GRANT && !keep ? bus.sel : last;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= 2'd2;
      cnt      <= 8'd0;
      bus.gnt  <= 3'b000;
      bus.sel  <= 2'd0;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      cnt      <= cnt_n;
      bus.gnt  <= gnt_n;
      bus.sel  <= sel_n;
      bus.busy <= any;
    end
  end
endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter: directed checks of grant order, hold cap, handoff, idle return and reset
module tb_mux3_rr_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  mux3_rr_arbiter_if bus();
  mux3_rr_arbiter #(.HOLD_MAX(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    check("busy_eq_or_gnt", 32'(bus.busy), 32'(|bus.gnt));
    check("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    if (bus.gnt != 3'b000)
      check("sel_match", 32'(bus.sel), bus.gnt[2] ? 32'd2 : bus.gnt[1] ? 32'd1 : 32'd0);
  endtask
  task automatic expect_out(input string tag, input logic [2:0] g, input logic [1:0] s, input logic b);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, "_sel"}, 32'(bus.sel), 32'(s));
    check({tag, "_busy"}, 32'(bus.busy), 32'(b));
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    expect_out("rst_pulse", 3'b000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    logic [2:0] order [4];
    order[0] = 3'b001;
    order[1] = 3'b010;
    order[2] = 3'b100;
    order[3] = 3'b001;
    bus.req = 3'b111;
    #3;
    expect_out("rst_hold", 3'b000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.req = 3'b010;
    @(posedge clk);
    #1;
    expect_out("rst_toggle", 3'b000, 2'd0, 1'b0);
    reset_n = 1'b1;
    step();
    expect_out("first_gnt", 3'b010, 2'd1, 1'b1);
    bus.req = 3'b000;
    step();
    expect_out("idle_ret", 3'b000, 2'd1, 1'b0);
    pulse_reset();
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 8; k++) begin
        step();
        check($sformatf("rr_g%0d_c%0d", g, k + 1), 32'(bus.gnt), 32'(order[g]));
      end
    bus.req = 3'b000;
    step();
    expect_out("rr_idle", 3'b000, 2'd0, 1'b0);
    pulse_reset();
    bus.req = 3'b001;
    step();
    expect_out("early_c1", 3'b001, 2'd0, 1'b1);
    bus.req = 3'b101;
    step();
    step();
    expect_out("early_c3", 3'b001, 2'd0, 1'b1);
    bus.req = 3'b100;
    step();
    expect_out("early_hand", 3'b100, 2'd2, 1'b1);
    bus.req = 3'b000;
    step();
    expect_out("idle_keep_sel", 3'b000, 2'd2, 1'b0);
    bus.req = 3'b001;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("timeout_c%0d", k + 1), 32'(bus.gnt), 32'(3'b001));
    end
    bus.req = 3'b000;
    step();
    expect_out("timeout_idle", 3'b000, 2'd0, 1'b0);
    bus.req = 3'b010;
    for (int k = 0; k < 4; k++) step();
    expect_out("mid_c4", 3'b010, 2'd1, 1'b1);
    reset_n = 1'b0;
    #1;
    expect_out("mid_rst", 3'b000, 2'd0, 1'b0);
    reset_n = 1'b1;
    bus.req = 3'b111;
    step();
    expect_out("post_rst", 3'b001, 2'd0, 1'b1);
    step();
    expect_out("post_rst_hold", 3'b001, 2'd0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
